serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values >=2.
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; legal values 1..WIDTH and must divide WIDTH exactly. N = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only when the block can accept it.
REQ-006 SHALL have port op  input  1  0 = subtract x-y, 1 = add x+y.
REQ-007 SHALL have port x  input  WIDTH  minuend/augend.
REQ-008 SHALL have port y  input  WIDTH  subtrahend/addend.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  WIDTH+1  bit WIDTH = borrow (sub) or carry (add); bits WIDTH-1:0 = difference/sum mod 2^WIDTH.
REQ-012 SHALL have ports overflow  output  1  signed two's-complement overflow, and zero  output  1  result[WIDTH-1:0]==0.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE after N digit steps; DONE->RUN on start, else DONE->IDLE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored with no effect.
REQ-015 SHALL latch x, y, op at the accepting edge E0; input changes after E0 SHALL NOT affect the operation.
REQ-016 SHALL process one DIGIT-bit slice per cycle LSB first at edges E1..EN, propagating borrow/carry between slices; initial borrow/carry-in = 0.
REQ-017 SHALL assert busy from E0 to EN (N cycles); busy low in IDLE and DONE.
REQ-018 SHALL assert done for exactly one cycle following EN; latency start-accepted-to-done = N cycles.
REQ-019 Subtract: result[WIDTH-1:0] = (x-y) mod 2^WIDTH; result[WIDTH] = 1 iff x<y unsigned.
REQ-020 Add: result = x+y as unsigned WIDTH+1-bit value.
REQ-021 SHALL update result, overflow, zero only at EN; they SHALL hold the last completed values until the next completion or reset.
REQ-022 Start accepted in DONE SHALL begin a new operation immediately (back-to-back, no idle cycle); done pulse still occurs for the previous completion.
REQ-023 N=1 SHALL be legal: busy one cycle, done one cycle later.

Reset
REQ-024 reset SHALL be sampled only at rising clk; it SHALL take priority over start and all other activity.
REQ-025 On reset: state=IDLE, busy=0, done=0, result=0, overflow=0, zero=0, internal counter/carry cleared.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse and no result update.

Configuration
REQ-027 Macro ADDSUB_FLAGS_EN: when defined, overflow and zero SHALL be computed per REQ-012 and updated at EN.
REQ-028 Without ADDSUB_FLAGS_EN, overflow and zero ports SHALL exist and be constant 0, with no flag logic generated.

Verification
REQ-029 WIDTH=8, DIGIT=1, op=0, x=100, y=37 -> done 8 cycles after start, result=9'h03F, busy high 8 cycles.
REQ-030 op=0, x=8'h05, y=8'h0A -> result=9'h1FB (borrow=1); with flags: overflow=0, zero=0.
REQ-031 With ADDSUB_FLAGS_EN: op=0, x=8'h80, y=8'h01 -> result=9'h07F, overflow=1; op=1, x=8'hFF, y=8'h01 -> result=9'h100, zero=1, overflow=0.
REQ-032 start re-pulsed with new operands during RUN -> ignored, original result delivered; start held in done cycle -> second operation completes exactly N cycles later.
REQ-033 reset asserted at 3rd RUN cycle -> next cycle busy=0, result=0, no done pulse ever for that operation.
REQ-034 WIDTH=8, DIGIT=4, op=1, x=8'h7F, y=8'h01 -> done 2 cycles after start, result=9'h080, overflow=1 with flags.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, N = WIDTH/DIGIT steps.
// Optional flag logic (overflow, zero) is built only when ADDSUB_FLAGS_EN is defined.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_acc;
    logic             r_op;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   r_result;

    logic             w_accept;
    logic             w_last;
    logic             w_step_end;
    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_step_end = (r_state == S_RUN) && w_last;

    // One digit step; the slice MSB is the carry (add) or borrow (sub) out.
    always_comb begin
        w_slice = '0;
        if (r_op) begin
            w_slice = {1'b0, r_x[DIGIT-1:0]} + {1'b0, r_y[DIGIT-1:0]}
                    + (DIGIT+1)'(r_carry);
        end else begin
            w_slice = {1'b0, r_x[DIGIT-1:0]} - {1'b0, r_y[DIGIT-1:0]}
                    - (DIGIT+1)'(r_carry);
        end
    end

    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last)   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, digit shifting and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
            if (w_accept) begin
                r_x     <= x;
                r_y     <= y;
                r_op    <= op;
                r_cnt   <= '0;
                r_carry <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_x     <= r_x >> DIGIT;
                r_y     <= r_y >> DIGIT;
                r_acc   <= w_acc_next;
                r_carry <= w_slice[DIGIT];
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result <= {w_slice[DIGIT], w_acc_next};
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

`ifdef ADDSUB_FLAGS_EN
    logic r_ovf;
    logic r_zero;
    logic w_xs;
    logic w_ys;
    logic w_rs;
    logic w_ovf;

    // At the last step the top slice holds the operand sign bits.
    assign w_xs  = r_x[DIGIT-1];
    assign w_ys  = r_y[DIGIT-1];
    assign w_rs  = w_slice[DIGIT-1];
    assign w_ovf = r_op ? ((w_xs == w_ys) && (w_rs != w_xs))
                        : ((w_xs != w_ys) && (w_rs != w_xs));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_step_end) begin
            r_ovf  <= w_ovf;
            r_zero <= (w_acc_next == '0);
        end
    end

    assign overflow = r_ovf;
    assign zero     = r_zero;
`else
    logic w_unused;
    assign w_unused = w_step_end;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8, DIGIT=1 and DIGIT=4 instances) with a result scoreboard.
module tb_serial_addsub;

    typedef struct {
        logic [8:0] res;
        logic       ovf;
        logic       zr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start4;
    logic       op;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy, done, overflow, zero;
    logic [8:0] result;
    logic       busy4, done4, overflow4, zero4;
    logic [8:0] result4;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .result(result), .overflow(overflow), .zero(zero)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .x(x), .y(y),
        .busy(busy4), .done(done4), .result(result4), .overflow(overflow4), .zero(zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   s;
        if (o) begin
            e.res = {1'b0, a} + {1'b0, b};
            s     = int'($signed(a)) + int'($signed(b));
        end else begin
            e.res = {1'b0, a} - {1'b0, b};
            s     = int'($signed(a)) - int'($signed(b));
        end
`ifdef ADDSUB_FLAGS_EN
        e.ovf = (s > 127) || (s < -128);
        e.zr  = (e.res[7:0] == 8'h00);
`else
        e.ovf = 1'b0;
        e.zr  = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, step past the accepting edge, then scramble the inputs.
    task automatic issue(input logic o, input logic [7:0] a, input logic [7:0] b);
        op    = o;
        x     = a;
        y     = b;
        start = 1'b1;
        sb_q.push_back(model(o, a, b));
        tick();
        start = 1'b0;
        op    = 1'($urandom);
        x     = 8'($urandom);
        y     = 8'($urandom);
        check("busy_after_accept", 32'(busy), 32'(1));
    endtask

    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nb++;
            tick();
            lat++;
        end
        check("done_seen", 32'(done), 32'(1));
    endtask

    task automatic compare(input string tag);
        exp_t e;
        check({tag, "_sb_size"}, 32'(sb_q.size()), 32'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_result"},   32'(result),   32'(e.res));
            check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
            check({tag, "_zero"},     32'(zero),     32'(e.zr));
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b);
        int lat;
        int nb;
        issue(o, a, b);
        wait_done(lat, nb);
        check({tag, "_latency"}, 32'(lat), 32'(8));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(8));
        compare(tag);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
        check({tag, "_busy_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int   lat;
        int   nb;
        logic saw_done;
        exp_t e4;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        start4   = 1'b0;
        op       = 1'b0;
        x        = 8'h00;
        y        = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy",     32'(busy),     32'(0));
        check("rst_done",     32'(done),     32'(0));
        check("rst_result",   32'(result),   32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_zero",     32'(zero),     32'(0));
        tick();

        run_op("sub_100_37", 1'b0, 8'd100, 8'd37);
        run_op("sub_05_0a",  1'b0, 8'h05, 8'h0A);
        run_op("sub_80_01",  1'b0, 8'h80, 8'h01);
        run_op("add_ff_01",  1'b1, 8'hFF, 8'h01);
        run_op("add_7f_01",  1'b1, 8'h7F, 8'h01);
        run_op("sub_equal",  1'b0, 8'h5A, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            run_op("rand", 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // Start re-pulsed with new operands during RUN is ignored.
        issue(1'b1, 8'h34, 8'h12);
        repeat (3) tick();
        op = 1'b0; x = 8'h01; y = 8'hF0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, nb);
        check("ignore_latency", 32'(lat), 32'(4));
        compare("ignore");

        // Start held in the done cycle launches the next operation immediately.
        issue(1'b0, 8'h10, 8'h20);
        wait_done(lat, nb);
        compare("b2b_first");
        op = 1'b1; x = 8'hC3; y = 8'h3C; start = 1'b1;
        sb_q.push_back(model(1'b1, 8'hC3, 8'h3C));
        tick();
        start = 1'b0;
        check("b2b_busy",      32'(busy), 32'(1));
        check("b2b_done_drop", 32'(done), 32'(0));
        check("b2b_hold_prev", 32'(result), 32'(9'h1F0));
        wait_done(lat, nb);
        check("b2b_latency", 32'(lat), 32'(8));
        compare("b2b_second");
        tick();

        // Reset during the third RUN cycle aborts with no done pulse.
        issue(1'b1, 8'h11, 8'h22);
        void'(sb_q.pop_back());
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",   32'(busy),   32'(0));
        check("abort_done",   32'(done),   32'(0));
        check("abort_result", 32'(result), 32'(0));
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(saw_done), 32'(0));

        // DIGIT=4 instance: two-step operation.
        op = 1'b1; x = 8'h7F; y = 8'h01; start4 = 1'b1;
        e4 = model(1'b1, 8'h7F, 8'h01);
        tick();
        start4 = 1'b0;
        x = 8'h00;
        lat = 0;
        while (done4 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("d4_done_seen", 32'(done4),     32'(1));
        check("d4_latency",   32'(lat),       32'(2));
        check("d4_result",    32'(result4),   32'(e4.res));
        check("d4_overflow",  32'(overflow4), 32'(e4.ovf));
        check("d4_zero",      32'(zero4),     32'(e4.zr));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
